bpu_cnt_queue: RTL

Parametrised in-flight saturating-counter queue for the branch predictor. Each lookup pushes the predicted PHT counter and its PHT index. At branch resolution the head entry is popped, and the block returns the saturated-updated counter for PHT writeback. It supports configurable counter width and depth, an almost-full watermark, an occupancy count, a mispredict flush, and a sticky overflow flag.

---
 rtl/bpu_cnt_queue.sv | 89 ++++++++
 1 files changed

// File: rtl/bpu_cnt_queue.sv
// In-flight saturating-counter queue: predictions are pushed at lookup, popped at
// resolution, and the head counter is returned saturated-updated for PHT writeback.
module bpu_cnt_queue #(
    parameter int CNT_WIDTH    = 2,
    parameter int IDX_WIDTH    = 10,
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [CNT_WIDTH-1:0]   i_push_cnt,
    input  logic [IDX_WIDTH-1:0]   i_push_idx,
    output logic                   o_push_rdy,
    input  logic                   i_pop,
    input  logic                   i_pop_taken,
    output logic                   o_head_vld,
    output logic [CNT_WIDTH-1:0]   o_head_cnt,
    output logic [IDX_WIDTH-1:0]   o_head_idx,
    output logic                   o_upd_vld,
    output logic [CNT_WIDTH-1:0]   o_upd_cnt,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_afull,
    output logic                   o_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [PW-1:0]        DEPTH_P = PW'(DEPTH);

    typedef struct packed {
        logic [CNT_WIDTH-1:0] cnt;
        logic [IDX_WIDTH-1:0] idx;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] free_slots;
    logic          full, empty, push_acc, pop_acc, ovf;

    // Extra wrap bit on each pointer distinguishes full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign push_acc = i_push & ~full & ~i_flush;
    assign pop_acc  = i_pop & ~empty & ~i_flush;

    assign head       = mem[rd_ptr[AW-1:0]];
    assign o_head_cnt = head.cnt;
    assign o_head_idx = head.idx;
    assign o_head_vld = ~empty;
    assign o_push_rdy = ~full;
    assign o_upd_vld  = i_pop & ~empty;
    assign o_count    = wr_ptr - rd_ptr;
    assign free_slots = DEPTH_P - o_count;
    assign o_afull    = (32'(free_slots) <= AFULL_MARGIN);
    assign o_ovf      = ovf;

    always_comb begin
        o_upd_cnt = head.cnt;
        if (i_pop_taken) begin
            if (head.cnt != CNT_MAX) o_upd_cnt = head.cnt + CNT_WIDTH'(1);
        end else if (head.cnt != '0) begin
            o_upd_cnt = head.cnt - CNT_WIDTH'(1);
        end
    end

    // Storage is never cleared; validity comes from the pointers alone.
    always_ff @(posedge i_clk) begin
        if (push_acc) mem[wr_ptr[AW-1:0]] <= '{cnt: i_push_cnt, idx: i_push_idx};
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else if (i_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + PW'(1);
            if (pop_acc)  rd_ptr <= rd_ptr + PW'(1);
            if (i_push & full) ovf <= 1'b1;
        end
    end
endmodule
